// File: rtl/cpuc_mul_ctrl_pkg.sv
// Purpose : shared widths and FSM state type for the CPU-core iterative multiplier.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DATA_WIDTH  - operand/result width used by every cpuc_* block
//   MUL_CNT_W   - width of the shift-add step counter (holds 0..DATA_WIDTH-1)
//   t_mul_state - multiplier controller states
package cpuc_package;

  localparam int DATA_WIDTH = 32;

  // Counter only has to reach DATA_WIDTH-1, so clog2 of the width is enough.
  localparam int MUL_CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } t_mul_state;

endpackage

// File: rtl/cpuc_mul_ctrl_step.sv
// Purpose : one combinational shift-add multiply step (radix-2).
// Latency : 0 cycles, pure combinational.
// Backpressure: none; the caller decides when to register the results.
//
// Ports:
//   a       in  DATA_WIDTH  current (shifted) multiplicand
//   b       in  DATA_WIDTH  current (shifted) multiplier
//   acc     in  DATA_WIDTH  partial product so far
//   a_nxt   out DATA_WIDTH  multiplicand shifted left by one
//   b_nxt   out DATA_WIDTH  multiplier shifted right by one
//   acc_nxt out DATA_WIDTH  acc + a when b[0] is set, else acc (wraps mod 2^DATA_WIDTH)
module cpuc_mul_step
  import cpuc_package::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] acc,
  output logic [DATA_WIDTH-1:0] a_nxt,
  output logic [DATA_WIDTH-1:0] b_nxt,
  output logic [DATA_WIDTH-1:0] acc_nxt
);

  // The sum is deliberately kept at DATA_WIDTH bits: only the low half of
  // the product is ever returned, so the carry out is simply dropped.
  assign acc_nxt = b[0] ? (acc + a) : acc;
  assign a_nxt   = a << 1;
  assign b_nxt   = b >> 1;

endmodule

// File: rtl/cpuc_mul_ctrl.sv
// Purpose : iterative shift-add multiplier controller, one operation in flight.
// Latency : DATA_WIDTH run cycles (EARLY_TERM=0) or msb_index(req_b)+1 run cycles (EARLY_TERM=1).
// Backpressure: result held in DONE until rsp_ready; req_ready only high in IDLE.
//
// Ports:
//   Clk        in   1           single clock, rising edge
//   Rst        in   1           synchronous active-high reset
//   req_valid  in   1           requester presents operands
//   req_ready  out  1           operands accepted (IDLE and not in reset)
//   req_a      in   DATA_WIDTH  multiplicand
//   req_b      in   DATA_WIDTH  multiplier
//   rsp_valid  out  1           result available (DONE)
//   rsp_ready  in   1           consumer takes result
//   rsp_data   out  DATA_WIDTH  low DATA_WIDTH bits of req_a*req_b
//   busy       out  1           operation in RUN or DONE
module cpuc_mul_ctrl
  import cpuc_package::*;
#(
  parameter int EARLY_TERM = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy
);

  localparam logic [MUL_CNT_W-1:0] CNT_LAST = MUL_CNT_W'(DATA_WIDTH - 1);
  localparam logic [MUL_CNT_W-1:0] CNT_ONE  = MUL_CNT_W'(1);
  localparam bit                   ET_ON    = (EARLY_TERM != 0);

  t_mul_state            state;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [MUL_CNT_W-1:0]  cnt_q;

  logic [DATA_WIDTH-1:0] a_step;
  logic [DATA_WIDTH-1:0] b_step;
  logic [DATA_WIDTH-1:0] acc_step;

  logic accept;
  logic rsp_take;
  logic last_run;
  logic skip_run;

  cpuc_mul_step u_step (
    .a       (a_q),
    .b       (b_q),
    .acc     (acc_q),
    .a_nxt   (a_step),
    .b_nxt   (b_step),
    .acc_nxt (acc_step)
  );

  // Reset masks req_ready so a requester never sees a handshake that the
  // reset branch of the state register would silently discard.
  assign req_ready = (state == MUL_IDLE) && !Rst;
  assign rsp_valid = (state == MUL_DONE);
  assign busy      = (state != MUL_IDLE);
  assign rsp_data  = acc_q;

  assign accept   = req_valid && req_ready;
  assign rsp_take = rsp_valid && rsp_ready;

  // A zero multiplier has nothing to add, so with early termination the
  // product (0) is already final at accept time.
  assign skip_run = ET_ON && (req_b == '0);

  // Last RUN cycle: either the counter is at its final step, or (early
  // termination) the multiplier that remains after this step has no set bits.
  assign last_run = (cnt_q == CNT_LAST) || (ET_ON && (b_step == '0));

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= MUL_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            acc_q <= '0;
            cnt_q <= '0;
            state <= skip_run ? MUL_DONE : MUL_RUN;
          end
        end
        MUL_RUN: begin
          a_q   <= a_step;
          b_q   <= b_step;
          acc_q <= acc_step;
          cnt_q <= cnt_q + CNT_ONE;
          if (last_run) begin
            state <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          // acc_q is frozen here so rsp_data stays stable while stalled.
          if (rsp_take) begin
            state <= MUL_IDLE;
          end
        end
        default: begin
          state <= MUL_IDLE;
        end
      endcase
    end
  end

endmodule
